// File: rtl/serial_word_packer_pkg.sv
// Shared constants for the serial word packer.
// Holds the FSM encoding and the default word width.
package serial_word_packer_pkg;

  localparam int SWP_WIDTH = 32;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } swp_state_e;

endpackage

// File: rtl/serial_word_packer.sv
// Packs a serial bit stream into WIDTH-bit words.
// A full word skips HOLD when the output register is free.
module serial_word_packer
  import serial_word_packer_pkg::*;
#(
  parameter int WIDTH     = SWP_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [5:0]       bit_count,
  output logic             frame_err
);

  swp_state_e       state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             bit_acc;
  logic             word_xfer;
  logic             out_free;
  logic             restart;
  logic             last_bit;
  logic [5:0]       pos;
  logic [5:0]       first_pos;
  logic [WIDTH-1:0] bit_vec;
  logic [WIDTH-1:0] first_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bit_ready = (state_q == FILL) && !rst;
  assign bit_acc   = bit_valid && bit_ready;
  assign word_xfer = valid_q && word_ready;
  assign out_free  = !valid_q || word_ready;
  assign restart   = bit_acc && frame_start
                     && (count_q != 6'd0);
  assign last_bit  = bit_acc && !restart
                     && (count_q == 6'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (last_bit && !out_free) state_d = HOLD;
      HOLD: if (out_free) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    first_pos = MSB_FIRST ? 6'(WIDTH - 1) : 6'd0;
    pos       = MSB_FIRST ? (first_pos - count_q) : count_q;
    bit_vec   = WIDTH'(bit_in) << pos;
    first_vec = WIDTH'(bit_in) << first_pos;

    count_d = count_q;
    asm_d   = asm_q;
    word_d  = word_q;
    valid_d = word_xfer ? 1'b0 : valid_q;
    err_d   = 1'b0;

    unique case (state_q)
      FILL: begin
        if (restart) begin
          asm_d   = first_vec;
          count_d = 6'd1;
          err_d   = 1'b1;
        end else if (last_bit && out_free) begin
          word_d  = asm_q | bit_vec;
          valid_d = 1'b1;
          asm_d   = '0;
          count_d = 6'd0;
        end else if (last_bit) begin
          asm_d   = asm_q | bit_vec;
          count_d = 6'(WIDTH);
        end else if (bit_acc) begin
          asm_d   = asm_q | bit_vec;
          count_d = count_q + 6'd1;
        end
      end
      HOLD: begin
        if (out_free) begin
          word_d  = asm_q;
          valid_d = 1'b1;
          asm_d   = '0;
          count_d = 6'd0;
        end
      end
      default: ;
    endcase
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign bit_count  = count_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed bench for serial_word_packer.
// Instance a is LSB-first, instance b is MSB-first.
module tb_serial_word_packer;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_bit, a_bv, a_br, a_fs, a_wv, a_wr, a_err;
  logic [31:0] a_word;
  logic [5:0]  a_cnt;

  logic        b_bit, b_bv, b_br, b_fs, b_wv, b_wr, b_err;
  logic [31:0] b_word;
  logic [5:0]  b_cnt;

  int n_run  = 0;
  int n_fail = 0;
  int not_rdy;
  int words_seen;

  always #5 clk = ~clk;

  serial_word_packer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst),
    .bit_in(a_bit), .bit_valid(a_bv), .bit_ready(a_br),
    .frame_start(a_fs),
    .word_out(a_word), .word_valid(a_wv), .word_ready(a_wr),
    .bit_count(a_cnt), .frame_err(a_err)
  );

  serial_word_packer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst),
    .bit_in(b_bit), .bit_valid(b_bv), .bit_ready(b_br),
    .frame_start(b_fs),
    .word_out(b_word), .word_valid(b_wv), .word_ready(b_wr),
    .bit_count(b_cnt), .frame_err(b_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic b, input logic fs);
    a_bit = b; a_fs = fs; a_bv = 1'b1;
    if (!a_br) not_rdy++;
    tick();
    if (a_wv && a_wr) words_seen++;
    a_bv = 1'b0; a_fs = 1'b0;
  endtask

  task automatic send_b(input logic b);
    b_bit = b; b_bv = 1'b1;
    tick();
    b_bv = 1'b0;
  endtask

  task automatic send_word_a(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_a(w[i], 1'b0);
  endtask

  logic [31:0] w1, w2, w3, z;

  initial begin
    rst = 1'b1;
    a_bit = 0; a_bv = 0; a_fs = 0; a_wr = 1;
    b_bit = 0; b_bv = 0; b_fs = 0; b_wr = 1;
    not_rdy = 0; words_seen = 0;
    tick(); tick();
    check("rst_bit_ready", 32'(a_br), 32'd0);
    check("rst_word_valid", 32'(a_wv), 32'd0);
    check("rst_bit_count", 32'(a_cnt), 32'd0);
    check("rst_word_out", a_word, 32'd0);
    check("rst_frame_err", 32'(a_err), 32'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 32'(a_br), 32'd1);

    w1 = 32'hA5A50F0F;
    send_a(w1[0], 1'b1);
    check("fs_at_zero_err", 32'(a_err), 32'd0);
    check("fs_at_zero_cnt", 32'(a_cnt), 32'd1);
    for (int i = 1; i < 31; i++) send_a(w1[i], 1'b0);
    check("valid_before_last", 32'(a_wv), 32'd0);
    send_a(w1[31], 1'b0);
    check("a5_valid", 32'(a_wv), 32'd1);
    check("a5_word", a_word, 32'hA5A50F0F);
    check("a5_count", 32'(a_cnt), 32'd0);
    tick();
    check("xfer_clears_valid", 32'(a_wv), 32'd0);
    check("word_held", a_word, 32'hA5A50F0F);

    w1 = 32'h13579BDF; w2 = 32'h2468ACE0; w3 = 32'hFFFF0001;
    not_rdy = 0; words_seen = 0;
    send_word_a(w1, 32);
    check("stream_w1", a_word, w1);
    send_word_a(w2, 32);
    check("stream_w2", a_word, w2);
    send_word_a(w3, 32);
    check("stream_w3", a_word, w3);
    tick();
    check("stream_ready_gaps", 32'(not_rdy), 32'd0);
    check("stream_words", 32'(words_seen), 32'd3);

    a_wr = 1'b0;
    w1 = 32'hDEADBEEF; w2 = 32'h0BADF00D;
    send_word_a(w1, 32);
    check("bp_w1_valid", 32'(a_wv), 32'd1);
    send_word_a(w2, 32);
    check("bp_ready_low", 32'(a_br), 32'd0);
    check("bp_count", 32'(a_cnt), 32'd32);
    check("bp_w1_stable", a_word, w1);
    tick();
    check("bp_hold_stays", 32'(a_br), 32'd0);
    a_wr = 1'b1;
    tick();
    check("bp_w2_word", a_word, w2);
    check("bp_w2_valid", 32'(a_wv), 32'd1);
    check("bp_ready_back", 32'(a_br), 32'd1);
    check("bp_count_zero", 32'(a_cnt), 32'd0);
    tick();
    check("bp_drained", 32'(a_wv), 32'd0);

    z = 32'h12345679;
    send_word_a(32'h000003FF, 10);
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    check("fs_idle_ignored", 32'(a_cnt), 32'd10);
    check("fs_idle_no_err", 32'(a_err), 32'd0);
    send_a(z[0], 1'b1);
    check("restart_err", 32'(a_err), 32'd1);
    check("restart_cnt", 32'(a_cnt), 32'd1);
    send_a(z[1], 1'b0);
    check("restart_err_pulse", 32'(a_err), 32'd0);
    for (int i = 2; i < 32; i++) send_a(z[i], 1'b0);
    check("restart_word", a_word, z);
    check("restart_valid", 32'(a_wv), 32'd1);
    tick();

    send_word_a(32'hFFFFFFFF, 20);
    rst = 1'b1;
    tick();
    check("mid_rst_cnt", 32'(a_cnt), 32'd0);
    check("mid_rst_word", a_word, 32'd0);
    check("mid_rst_err", 32'(a_err), 32'd0);
    rst = 1'b0;
    a_wr = 1'b0;
    send_word_a(32'h11111111, 32);
    send_word_a(32'h22222222, 32);
    check("pre_rst_hold", 32'(a_cnt), 32'd32);
    rst = 1'b1;
    tick();
    check("hold_rst_cnt", 32'(a_cnt), 32'd0);
    check("hold_rst_valid", 32'(a_wv), 32'd0);
    check("hold_rst_ready", 32'(a_br), 32'd0);
    check("hold_rst_err", 32'(a_err), 32'd0);
    rst = 1'b0;
    a_wr = 1'b1;
    #1;
    check("hold_rst_ready1", 32'(a_br), 32'd1);
    w1 = 32'hCAFE1234;
    send_word_a(w1, 32);
    check("post_rst_word", a_word, w1);
    check("post_rst_err", 32'(a_err), 32'd0);

    w1 = 32'h80000001;
    for (int i = 31; i >= 0; i--) send_b(w1[i]);
    check("msb_word", b_word, 32'h80000001);
    check("msb_valid", 32'(b_wv), 32'd1);
    w2 = 32'h12345678;
    for (int i = 31; i >= 0; i--) send_b(w2[i]);
    check("msb_order", b_word, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
